// File: rtl/int_to_float_seq.sv
// ============================================================================
// int_to_float_seq : sequential signed int32 -> IEEE-754 binary32 converter
// Rev 1.0
// ============================================================================
`default_nettype none

module int_to_float_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] f,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    NORM  = 2'd2,
    ROUND = 2'd3
  } state_t;

  localparam logic [7:0] C_EXP_BIAS_MAX = 8'd158;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_opnd;
  logic [31:0] r_mag;
  logic [7:0]  r_exp;
  logic        r_sign;

  logic [31:0] w_mag_abs;
  logic        w_mag_zero;
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_mant_sum;
  logic [7:0]  w_exp_rnd;

  // Two's-complement negate; 0x80000000 maps onto itself, which is the correct magnitude.
  assign w_mag_abs  = r_opnd[31] ? (~r_opnd + 32'd1) : r_opnd;
  assign w_mag_zero = (w_mag_abs == 32'd0);

  assign w_mant     = r_mag[30:8];
  assign w_guard    = r_mag[7];
  assign w_sticky   = |r_mag[6:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_round_up};
  assign w_exp_rnd  = r_exp + {7'd0, w_mant_sum[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = w_mag_zero ? IDLE : NORM;
      NORM:    if (r_mag[31]) w_next = ROUND;
      ROUND:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd  <= 32'd0;
      r_mag   <= 32'd0;
      r_exp   <= 8'd0;
      r_sign  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= 32'd0;
      inexact <= 1'b0;
    end else begin
      busy <= (w_next != IDLE);
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) r_opnd <= a;
        end
        LOAD: begin
          r_sign <= r_opnd[31];
          r_mag  <= w_mag_abs;
          r_exp  <= C_EXP_BIAS_MAX;
          if (w_mag_zero) begin
            f       <= 32'd0;
            inexact <= 1'b0;
            done    <= 1'b1;
          end
        end
        NORM: begin
          if (!r_mag[31]) begin
            r_mag <= {r_mag[30:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end
        end
        ROUND: begin
          // A carry out of the 23-bit field leaves the fraction at zero with exp bumped.
          f       <= {r_sign, w_exp_rnd, w_mant_sum[22:0]};
          inexact <= w_guard | w_sticky;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
